// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - MIPS32 multiply/divide unit holding architectural HI/LO
// Optional feature macro: MDU_MADD_EN (compiles in MADD/MADDU/MSUB/MSUBU, ops 6-9).
`timescale 1ns/1ps
module mdu_hilo #(
  parameter int MUL_STAGES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_sign,
  input  logic [63:0] mul_prod,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

  localparam logic [4:0] MUL_LAST = 5'(MUL_STAGES - 1);
  localparam logic [4:0] DIV_LAST = 5'd31;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

`ifdef MDU_MADD_EN
  typedef enum logic [1:0] {ACC_WR, ACC_ADD, ACC_SUB} acc_e;
  acc_e acc_op_q, acc_op_d;
`endif

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic        mul_sign_q, mul_sign_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [4:0]  cnt_q, cnt_d;
  // Divider: quo_q starts as the dividend magnitude and is shifted out MSB
  // first while quotient bits shift in at the LSB.
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

  logic        div_signed;
  logic [32:0] div_shift, div_trial;
  logic        div_ge;
  logic [63:0] prod_sel;

  assign div_signed = (op == OP_DIV);

  // Product seen at commit: direct from mul, or through extra pipeline stages
  generate
    if (MUL_STAGES <= 1) begin : g_prod_direct
      assign prod_sel = mul_prod;
    end else begin : g_prod_pipe
      logic [63:0] pipe_q [MUL_STAGES-1];
      // Product pipeline registers between mul and the HI/LO commit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < MUL_STAGES - 1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= mul_prod;
          for (int i = 1; i < MUL_STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign prod_sel = pipe_q[MUL_STAGES-2];
    end
  endgenerate

  // Restoring step: trial subtraction, borrow-out clear means the bit is 1
  always_comb begin
    div_shift = {rem_q, quo_q[31]};
    div_trial = div_shift - {1'b0, dvsr_q};
    div_ge    = ~div_trial[32];
  end

  // Next-state and datapath update for the IDLE/MUL/DIV/FIX sequencer
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    mul_sign_d = mul_sign_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
`ifdef MDU_MADD_EN
    acc_op_d   = acc_op_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              mul_a_d    = op_a;
              mul_b_d    = op_b;
              mul_sign_d = (op == OP_MULT);
              cnt_d      = '0;
              busy_d     = 1'b1;
              state_d    = S_MUL;
`ifdef MDU_MADD_EN
              acc_op_d   = ACC_WR;
`endif
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              mul_a_d    = op_a;
              mul_b_d    = op_b;
              mul_sign_d = (op == OP_MADD) || (op == OP_MSUB);
              acc_op_d   = ((op == OP_MADD) || (op == OP_MADDU)) ? ACC_ADD : ACC_SUB;
              cnt_d      = '0;
              busy_d     = 1'b1;
              state_d    = S_MUL;
            end
`endif
            OP_DIV, OP_DIVU: begin
              rem_d     = '0;
              quo_d     = (div_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
              dvsr_d    = (div_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;
              neg_quo_d = div_signed && (op_a[31] ^ op_b[31]);
              neg_rem_d = div_signed && op_a[31];
              cnt_d     = '0;
              busy_d    = 1'b1;
              state_d   = S_DIV;
            end
            OP_MTHI: hi_d = op_a;
            OP_MTLO: lo_d = op_a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == MUL_LAST) begin
`ifdef MDU_MADD_EN
          case (acc_op_q)
            ACC_ADD: {hi_d, lo_d} = {hi_q, lo_q} + prod_sel;
            ACC_SUB: {hi_d, lo_d} = {hi_q, lo_q} - prod_sel;
            default: {hi_d, lo_d} = prod_sel;
          endcase
`else
          {hi_d, lo_d} = prod_sel;
`endif
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DIV: begin
        rem_d = div_ge ? div_trial[31:0] : div_shift[31:0];
        quo_d = {quo_q[30:0], div_ge};
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_FIX: begin
        // Divide-by-zero falls out naturally: quotient all ones, remainder |a|
        lo_d    = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
        hi_d    = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_sign_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
`ifdef MDU_MADD_EN
      acc_op_q   <= ACC_WR;
`endif
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mul_sign_q <= mul_sign_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
`ifdef MDU_MADD_EN
      acc_op_q   <= acc_op_d;
`endif
    end
  end

  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign mul_sign = mul_sign_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - scoreboard testbench for mdu_hilo
`timescale 1ns/1ps
module tb_mdu_hilo;

  localparam int MS = 2;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        op_valid = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [31:0] mul_a, mul_b;
  logic        mul_sign;
  logic [63:0] mul_prod;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] mon_e;

  mdu_hilo #(.MUL_STAGES(MS)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op),
    .op_a(op_a), .op_b(op_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_sign(mul_sign), .mul_prod(mul_prod), .busy(busy),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Stands in for the combinational mul block
  assign mul_prod = mul_sign
    ? ($signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b}))
    : ({32'b0, mul_a} * {32'b0, mul_b});

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural model: HI/LO after each op, from plain integer arithmetic
  task automatic model_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output bit multi);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    multi = 1'b0;
    case (o)
      OP_MULT:  begin p = sa * sb; {m_hi, m_lo} = p; multi = 1'b1; end
      OP_MULTU: begin p = ua * ub; {m_hi, m_lo} = p; multi = 1'b1; end
      OP_DIV: begin
        multi = 1'b1;
        if (sb == 0) begin
          m_hi = a;
          m_lo = (sa < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF;
        end else begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      OP_DIVU: begin
        multi = 1'b1;
        if (ub == 0) begin
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
        end else begin
          p = ua / ub;
          m_lo = p[31:0];
          p = ua % ub;
          m_hi = p[31:0];
        end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
`ifdef MDU_MADD_EN
      OP_MADD:  begin p = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} + p; multi = 1'b1; end
      OP_MADDU: begin p = ua * ub; {m_hi, m_lo} = {m_hi, m_lo} + p; multi = 1'b1; end
      OP_MSUB:  begin p = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} - p; multi = 1'b1; end
      OP_MSUBU: begin p = ua * ub; {m_hi, m_lo} = {m_hi, m_lo} - p; multi = 1'b1; end
`endif
      default: ;
    endcase
  endtask

  // Issue one op from a falling edge; returns at a falling edge once idle
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    bit multi;
    bit is_div;
    int n;
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    check("wait_idle", 64'(busy), 64'd0);
    model_op(o, a, b, multi);
    is_div = (o == OP_DIV) || (o == OP_DIVU);
    if (multi) exp_q.push_back({m_hi, m_lo});
    op_valid = 1'b1; op = o; op_a = a; op_b = b;
    @(posedge clk); #1;
    op_valid = 1'b0;
    if (multi) begin
      @(negedge clk);
      if (!is_div) begin
        check("mul_sign", 64'(mul_sign), 64'((o == OP_MULT) || (o == OP_MADD) || (o == OP_MSUB)));
        check("mul_ops", {mul_a, mul_b}, {a, b});
      end
      n = 0;
      while (busy && n < 100) begin n++; @(negedge clk); end
      check("busy_cycles", 64'(n), is_div ? 64'd33 : 64'(MS));
    end else begin
      check("hilo_single", {hi, lo}, {m_hi, m_lo});
      @(negedge clk);
      check("busy_single", 64'(busy), 64'd0);
    end
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the next queued HI/LO expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got done=1 with hi=%h lo=%h, expected no done", hi, lo);
      end else begin
        mon_e = exp_q.pop_front();
        check("hilo_commit", {hi, lo}, mon_e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit multi;
    int n;
    logic [3:0] ro;
    logic [31:0] ra, rb;

    #1 rst_n = 1'b0;
    #11;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_mul", {mul_a, mul_b}, 64'd0);
    check("rst_ctl", {61'd0, mul_sign, busy, done}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(OP_MULT, 32'hFFFF0001, 32'h0000_0003);
    check("tp_mult", {hi, lo}, 64'hFFFFFFFF_FFFD0003);
    do_op(OP_MULTU, 32'hFFFF0001, 32'h0000_0003);
    check("tp_multu", {hi, lo}, 64'h00000002_FFFD0003);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    check("tp_div", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(OP_DIVU, 32'd100, 32'd7);
    check("tp_divu", {hi, lo}, 64'h00000002_0000000E);
    do_op(OP_DIVU, 32'd5, 32'd0);
    check("tp_divu0", {hi, lo}, 64'h00000005_FFFFFFFF);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("tp_div_ovf", {hi, lo}, 64'h00000000_80000000);
    do_op(OP_DIV, 32'hFFFF_FFFB, 32'd0);
    check("tp_div0_neg", {hi, lo}, 64'hFFFFFFFB_00000001);
    do_op(OP_DIV, 32'd9, 32'hFFFF_FFFE);
    check("tp_div_negb", {hi, lo}, 64'h00000001_FFFFFFFC);

    do_op(OP_MTHI, 32'h0, 32'h0);
    do_op(OP_MTLO, 32'hFFFF_FFFF, 32'h0);
    do_op(OP_MADDU, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    check("tp_maddu", {hi, lo}, 64'h00000001_00000000);
`else
    check("tp_maddu_off", {hi, lo}, 64'h00000000_FFFFFFFF);
`endif
    do_op(OP_MSUBU, 32'd1, 32'd1);
    check("tp_msubu", {hi, lo}, 64'h00000000_FFFFFFFF);
    do_op(4'd12, 32'h1234_5678, 32'h9ABC_DEF0);
    check("tp_badop", {hi, lo}, 64'h00000000_FFFFFFFF);

    for (int i = 0; i < 60; i++) begin
      ro = (i % 15 == 14) ? 4'd13 : 4'($urandom_range(0, 9));
      ra = rnd_word();
      rb = rnd_word();
      do_op(ro, ra, rb);
    end

    // Reset in the middle of a divide: abort, clear, no done
    model_op(OP_DIV, 32'd12345, 32'd17, multi);
    exp_q.push_back({m_hi, m_lo});
    op_valid = 1'b1; op = OP_DIV; op_a = 32'd12345; op_b = 32'd17;
    @(posedge clk); #1 op_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_done", 64'(done), 64'd0);
    exp_q.delete();
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_quiet", {62'd0, busy, done}, 64'd0);

    // Requests presented while busy must be ignored
    model_op(OP_DIVU, 32'd1000, 32'd3, multi);
    exp_q.push_back({m_hi, m_lo});
    op_valid = 1'b1; op = OP_DIVU; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1 op_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("ign_busy", 64'(busy), 64'd1);
    op_valid = 1'b1; op = OP_MTHI; op_a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    op = OP_MULT; op_a = 32'h7; op_b = 32'h9;
    @(posedge clk); #1 op_valid = 1'b0;
    check("ign_hilo_mid", {hi, lo}, 64'd0);
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin n++; @(negedge clk); end
    check("ign_idle", 64'(busy), 64'd0);
    check("ign_final", {hi, lo}, 64'h00000001_0000014D);
    repeat (5) @(negedge clk);
    check("ign_hold", {hi, lo}, {m_hi, m_lo});

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Sequential multiply/divide unit with the architectural HI/LO registers for the MIPS32 core. It sits directly downstream of the combinational `mul` block. It registers operands onto `mul`'s inputs, captures the 64-bit product, and runs a 32-iteration restoring divider internally. Results are committed to HI/LO, and `busy` stalls the execute stage until the result is ready.

## Interface
- `MUL_STAGES`, default 1: cycles from operand latch to product capture (1..3; extra stages are product pipeline registers).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `op_valid`  in  1  operation request; accepted on an edge where `op_valid && !busy`.
- `op`  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; other codes are ignored.
- `op_a`, `op_b`  in  32  rs / rt operands (dividend / divisor for DIV).
- `mul_a`, `mul_b`  out  32  registered operands to `mul` `data_a` / `data_b`.
- `mul_sign`  out  1  to `mul` `sign`; 1 for signed ops.
- `mul_prod`  in  64  from `mul` `data_c`; combinational in `mul_a` / `mul_b` / `mul_sign`.
- `busy`  out  1  high while a multiply or divide is in flight.
- `done`  out  1  one-cycle pulse in the cycle after HI/LO commit of a multi-cycle op.
- `hi`, `lo`  out  32  architectural HI / LO.

## Operation
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE, MULT/MULTU/MADD*/MSUB* accepted:
  - latch `op_a`/`op_b` into `mul_a`/`mul_b` and set `mul_sign`;
  - go to MUL;
  - counter runs MUL_STAGES cycles, then product is committed, return to IDLE.
- MULT/MULTU: `{hi,lo} <= mul_prod`.
- MADD/MADDU: `{hi,lo} <= {hi,lo} + mul_prod`.
- MSUB/MSUBU: `{hi,lo} <= {hi,lo} - mul_prod`.
- All 64-bit arithmetic wraps modulo 2^64.
- DIV/DIVU accepted, go to DIV:
  - latch magnitudes (|a|, |b| for DIV; raw values for DIVU) and the result signs;
  - perform 32 restoring iterations, one quotient bit per cycle, MSB first;
  - then FIX.
- FIX, one cycle:
  - DIV negates the quotient if sign(a) != sign(b) and negates the remainder if a < 0;
  - `lo` <= quotient, `hi` <= remainder;
  - return to IDLE. DIVU passes FIX unchanged.
- Divide by zero (no exception):
  - DIVU: LO=FFFFFFFF, HI=a.
  - DIV: HI=a; LO=FFFFFFFF if a >= 0, else 00000001.
- MTHI/MTLO: write `hi`/`lo` from `op_a` on the accept edge; no busy, no done.
- Ignored requests:
  - `op_valid` while `busy`, and unrecognized op codes, cause no state change;
  - the upstream stage must hold the request until `busy` is low.
- Signed DIV overflow, 80000000 / FFFFFFFF: LO=80000000, HI=0. This is the natural wrap result.

## Timing
- Reset (async assert, sync deassert at the next edge): state IDLE, `hi`=`lo`=0, `mul_a`=`mul_b`=0, `mul_sign`=0, `busy`=0, `done`=0, counters 0.
- Multiply, accepted at edge T0:
  - `busy`=1 from T0 through T(MUL_STAGES);
  - HI/LO commit at edge T(MUL_STAGES);
  - `busy`=0 and `done`=1 in the following cycle.
- Divide, accepted at T0: iterations at T1..T32, FIX commit at T33, so `busy` is high for 33 cycles.
- `busy` is registered and deasserts in the same cycle `done` pulses. A new op may be accepted in that cycle (back-to-back).
- `hi`/`lo` hold their old values until the commit edge. MFHI/MFLO reads while `busy` return stale data; the core stalls them on `busy`.
- Reset asserted mid-operation aborts it: HI/LO are cleared and no `done` pulse is issued.

## Configuration
- `MDU_MADD_EN` defined: ops 6-9 (MADD/MADDU/MSUB/MSUBU) and the 64-bit accumulate adder/subtractor are compiled in.
- `MDU_MADD_EN` undefined: ops 6-9 are treated as unrecognized and ignored (no busy, HI/LO unchanged); only MULT/MULTU product write remains on the multiply path.

## Test plan
- Reset, then MULT a=FFFF0001, b=00000003 -> after MUL_STAGES+1 cycles `done`, HI=FFFFFFFF, LO=FFFD0003.
- MULTU on the same operands -> HI=00000002, LO=FFFD0003; `mul_sign`=0 during the op.
- DIV a=FFFFFFF9 (-7), b=2 -> `busy` for 33 cycles, LO=FFFFFFFD, HI=FFFFFFFF.
- DIVU 100 / 7 -> LO=0000000E, HI=00000002.
- DIVU 5 / 0 -> LO=FFFFFFFF, HI=00000005.
- MTHI 0, MTLO FFFFFFFF, then MADDU 1*1 -> HI=00000001, LO=00000000. Then MSUBU 1*1 -> HI=0, LO=FFFFFFFF. Without `MDU_MADD_EN`, HI/LO stay unchanged and `busy` stays 0.
- Start DIV, pulse `rst_n` low at cycle 10 -> `busy`=0 immediately, HI=LO=0, no `done`. Then a request issued while `busy` is high is ignored and HI/LO match the first op only.
